// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer between NREQ byte
// requesters, with round-robin grant, burst hold and an s_tick idle gap.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   req_valid     bit i: requester i has a byte pending
//   req_data      requester i byte at [i*DBIT +: DBIT]
//   req_ready     one-cycle ack: byte of requester i captured
//   s_tick        oversampling tick shared with uart_tx
//   tx_done_tick  frame finished, from uart_tx
//   tx_start      one-cycle start pulse to uart_tx
//   din           frame byte, held until the next capture
//   grant_id      requester owning the current/last frame
//   busy          high whenever the arbiter is not idle
//
// Build option: define UART_TX_ARB_PRIO_EN to give requester 0 strict
// priority at every grant, overriding any burst hold of other requesters.

module uart_tx_arbiter #(
  parameter int  NREQ      = 4,
  parameter int  DBIT      = 8,
  parameter int  MAX_BURST = 4,
  parameter int  GAP_TICKS = 16,
  localparam int GW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DBIT-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 s_tick,
  input  logic                 tx_done_tick,
  output logic                 tx_start,
  output logic [DBIT-1:0]      din,
  output logic [GW-1:0]        grant_id,
  output logic                 busy
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int CW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [GW-1:0] LAST_RST  = GW'(NREQ - 1);
  localparam logic [CW-1:0] GAP_LAST  =
    CW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     last_q, last_d;
  logic [GW-1:0]     gid_q, gid_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [CW-1:0]     gap_q, gap_d;
  logic [DBIT-1:0]   din_q, din_d;
  logic [NREQ-1:0]   ready_q, ready_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;

  logic [DBIT-1:0]   data_a [NREQ];
  logic [GW-1:0]     rr_win;
  logic [GW-1:0]     win;
  logic [BW-1:0]     burst_nx;
  logic              hold_ok;
  logic              grant;
  logic              decide;

  for (genvar g = 0; g < NREQ; g++) begin : g_data
    assign data_a[g] = req_data[g*DBIT +: DBIT];
  end

  // First set bit of v scanning upward from last+1, wrapping at NREQ.
  function automatic logic [GW-1:0] rr_pick(
    input logic [NREQ-1:0] v,
    input logic [GW-1:0]   last
  );
    logic [GW:0]   sum;
    logic [GW-1:0] idx;
    logic [GW-1:0] pick;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      sum = {1'b0, last} + (GW+1)'(i);
      if (sum >= (GW+1)'(NREQ)) begin
        sum = sum - (GW+1)'(NREQ);
      end
      idx = sum[GW-1:0];
      if (!found && v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign rr_win  = rr_pick(req_valid, last_q);
  assign hold_ok = req_valid[gid_q] && (burst_q < BURST_MAX);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gid_d    = gid_q;
    burst_d  = burst_q;
    gap_d    = gap_q;
    din_d    = din_q;
    ready_d  = '0;
    start_d  = 1'b0;
    grant    = 1'b0;
    decide   = 1'b0;
    win      = rr_win;
    burst_nx = BW'(1);

    unique case (state_q)
      IDLE: begin
        grant = |req_valid;
      end
      BUSY: begin
        if (tx_done_tick) begin
          if (GAP_TICKS > 0) begin
            state_d = GAP;
            gap_d   = '0;
          end else begin
            decide = 1'b1;
          end
        end
      end
      GAP: begin
        if (s_tick) begin
          if (gap_q == GAP_LAST) begin
            decide = 1'b1;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // End of a frame (plus gap): chain straight into the next
    // capture when anyone is waiting, otherwise fall back to IDLE.
    if (decide) begin
      grant = |req_valid;
      if (!grant) begin
        state_d = IDLE;
      end
    end

    // Burst hold only applies between back-to-back frames.
    if (decide && hold_ok) begin
      win      = gid_q;
      burst_nx = burst_q + 1'b1;
    end

`ifdef UART_TX_ARB_PRIO_EN
    if (req_valid[0]) begin
      win      = '0;
      burst_nx = (decide && gid_q == '0 && burst_q < BURST_MAX)
               ? burst_q + 1'b1 : BW'(1);
    end
`endif

    if (grant) begin
      state_d      = BUSY;
      start_d      = 1'b1;
      ready_d[win] = 1'b1;
      gid_d        = win;
      last_d       = win;
      din_d        = data_a[win];
      burst_d      = burst_nx;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      gid_q   <= '0;
      burst_q <= '0;
      gap_q   <= '0;
      din_q   <= '0;
      ready_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      burst_q <= burst_d;
      gap_q   <= gap_d;
      din_q   <= din_d;
      ready_q <= ready_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready = ready_q;
  assign tx_start  = start_q;
  assign din       = din_q;
  assign grant_id  = gid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: two arbiters (MAX_BURST 1 and 2) against a
// grant-sequence model, vector table, reset sequences and random traffic.

module tb_uart_tx_arbiter;

  localparam int NREQ        = 4;
  localparam int DBIT        = 8;
  localparam int GW          = 2;
  localparam int GAP         = 16;
  localparam int ND          = 2;
  localparam int FRAME_TICKS = 160;
  localparam int NG          = 6;

  typedef struct {
    int              d;
    logic [NREQ-1:0] pat;
    int              exp_g [NG];
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 s_tick;
  logic [NREQ-1:0]      rv   [ND];
  logic [NREQ*DBIT-1:0] rd   [ND];
  logic                 dn   [ND];
  logic [NREQ-1:0]      rdy  [ND];
  logic                 ts   [ND];
  logic [DBIT-1:0]      dout [ND];
  logic [GW-1:0]        gid  [ND];
  logic                 bsy  [ND];

  int total = 0;
  int bad   = 0;

  int              rmode   [ND];
  int              m_ph    [ND];
  int              m_n     [ND];
  int              m_last  [ND];
  int              m_gid   [ND];
  int              m_burst [ND];
  logic [DBIT-1:0] m_din   [ND];
  bit              u_act   [ND];
  int              u_cnt   [ND];
  bit              g_on    [ND];
  int              g_cnt   [ND];
  int              glog    [ND][64];
  int              gcnt    [ND];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ(NREQ), .DBIT(DBIT), .MAX_BURST(1), .GAP_TICKS(GAP)
  ) dut0 (
    .clk(clk), .reset(rst_n),
    .req_valid(rv[0]), .req_data(rd[0]), .req_ready(rdy[0]),
    .s_tick(s_tick), .tx_done_tick(dn[0]),
    .tx_start(ts[0]), .din(dout[0]),
    .grant_id(gid[0]), .busy(bsy[0])
  );

  uart_tx_arbiter #(
    .NREQ(NREQ), .DBIT(DBIT), .MAX_BURST(2), .GAP_TICKS(GAP)
  ) dut1 (
    .clk(clk), .reset(rst_n),
    .req_valid(rv[1]), .req_data(rd[1]), .req_ready(rdy[1]),
    .s_tick(s_tick), .tx_done_tick(dn[1]),
    .tx_start(ts[1]), .din(dout[1]),
    .grant_id(gid[1]), .busy(bsy[1])
  );

  function automatic int maxb(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic mreset(input int d);
    m_ph[d]    = 0;
    m_n[d]     = 0;
    m_last[d]  = NREQ - 1;
    m_gid[d]   = 0;
    m_burst[d] = 0;
    m_din[d]   = '0;
    u_act[d]   = 1'b0;
    u_cnt[d]   = 0;
    g_on[d]    = 1'b0;
    g_cnt[d]   = 0;
    gcnt[d]    = 0;
    dn[d]      = 1'b0;
    for (int j = 0; j < 64; j++) glog[d][j] = -1;
  endtask

  // Winner for a grant: optional priority of 0, then burst hold
  // (only between chained frames), then round-robin after last.
  function automatic int pick(input int d,
                              input logic [NREQ-1:0] v,
                              input bit dec);
`ifdef UART_TX_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    if (dec && v[m_gid[d]] && m_burst[d] < maxb(d)) return m_gid[d];
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(m_last[d] + k) % NREQ]) return (m_last[d] + k) % NREQ;
    end
    return 0;
  endfunction

  // One clock: sample at the falling edge what the last rising edge
  // produced, advance the model, then drive the next inputs.
  task automatic step();
    logic                 st_s, dn_s, dn_nx;
    bit                   dec;
    logic [NREQ-1:0]      v_s, e_rdy;
    logic [NREQ*DBIT-1:0] d_s;
    logic [15:0]          e_vec, a_vec;
    int                   w;
    @(negedge clk);
    st_s = s_tick;
    for (int d = 0; d < ND; d++) begin
      v_s = rv[d];
      d_s = rd[d];
      dn_s = dn[d];
      w = -1;
      dec = 1'b0;
      if (!rst_n) begin
        mreset(d);
      end else begin
        case (m_ph[d])
          0: if (v_s != 0) w = pick(d, v_s, 1'b0);
          1: if (dn_s) begin
            m_ph[d] = 2;
            m_n[d]  = 0;
          end
          default: if (st_s) begin
            m_n[d]++;
            if (m_n[d] == GAP) begin
              dec = 1'b1;
              if (v_s != 0) w = pick(d, v_s, 1'b1);
              else m_ph[d] = 0;
            end
          end
        endcase
        if (w >= 0) begin
          m_burst[d] = (dec && w == m_gid[d] && m_burst[d] < maxb(d))
                     ? m_burst[d] + 1 : 1;
          m_gid[d]  = w;
          m_last[d] = w;
          m_din[d]  = d_s[w*DBIT +: DBIT];
          m_ph[d]   = 1;
        end
      end
      e_rdy = '0;
      if (w >= 0) e_rdy[w] = 1'b1;
      e_vec = {1'(w >= 0), 1'(m_ph[d] != 0), e_rdy,
               GW'(m_gid[d]), m_din[d]};
      a_vec = {ts[d], bsy[d], rdy[d], gid[d], dout[d]};
      chk($sformatf("cycle dut%0d", d), 64'(a_vec), 64'(e_vec));

      dn_nx = 1'b0;
      if (rst_n) begin
        if (g_on[d]) begin
          if (st_s) g_cnt[d]++;
          if (ts[d] || !bsy[d]) begin
            chk($sformatf("gap ticks dut%0d", d), g_cnt[d], GAP);
            g_on[d] = 1'b0;
          end
        end
        if (dn_s) begin
          g_on[d]  = 1'b1;
          g_cnt[d] = 0;
        end
        if (ts[d] && gcnt[d] < 64) begin
          glog[d][gcnt[d]] = int'(gid[d]);
          gcnt[d]++;
        end
        if (ts[d]) begin
          u_act[d] = 1'b1;
          u_cnt[d] = 0;
        end else if (u_act[d]) begin
          if (st_s) u_cnt[d]++;
          if (u_cnt[d] >= FRAME_TICKS) begin
            dn_nx    = 1'b1;
            u_act[d] = 1'b0;
          end
        end
        for (int i = 0; i < NREQ; i++) begin
          if (rdy[d][i]) begin
            rd[d][i*DBIT +: DBIT] = 8'($urandom);
            if (rmode[d] == 1 ||
                (rmode[d] == 2 && $urandom_range(1) == 0))
              rv[d][i] = 1'b0;
          end else if (rmode[d] == 2 && !rv[d][i] &&
                       $urandom_range(15) == 0) begin
            rv[d][i] = 1'b1;
          end
        end
      end
      dn[d] = dn_nx;
    end
    s_tick = 1'($urandom_range(1));
  endtask

  task automatic do_reset();
    for (int d = 0; d < ND; d++) begin
      rv[d]    = '0;
      rmode[d] = 0;
    end
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_grants(input int d, input int n, input int budget);
    int k;
    k = 0;
    while (gcnt[d] < n && k < budget) begin
      step();
      k++;
    end
    chk($sformatf("grants in budget dut%0d", d), gcnt[d], n);
  endtask

  initial begin
    vec_t tv [5];
    int   n;
    int   k;

    tv[0].d = 0; tv[0].pat = 4'b1111;
    tv[1].d = 1; tv[1].pat = 4'b0011;
    tv[2].d = 0; tv[2].pat = 4'b1001;
    tv[3].d = 0; tv[3].pat = 4'b0100;
    tv[4].d = 1; tv[4].pat = 4'b1010;
`ifdef UART_TX_ARB_PRIO_EN
    tv[0].exp_g = '{0, 0, 0, 0, 0, 0};
    tv[1].exp_g = '{0, 0, 0, 0, 0, 0};
    tv[2].exp_g = '{0, 0, 0, 0, 0, 0};
`else
    tv[0].exp_g = '{0, 1, 2, 3, 0, 1};
    tv[1].exp_g = '{0, 0, 1, 1, 0, 0};
    tv[2].exp_g = '{0, 3, 0, 3, 0, 3};
`endif
    tv[3].exp_g = '{2, 2, 2, 2, 2, 2};
    tv[4].exp_g = '{1, 1, 3, 3, 1, 1};

    rst_n  = 1'b1;
    s_tick = 1'b0;
    for (int d = 0; d < ND; d++) begin
      rv[d]    = '0;
      rd[d]    = $urandom;
      rmode[d] = 0;
      mreset(d);
    end

    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("async reset dut%0d", d),
          64'({ts[d], bsy[d], rdy[d], gid[d], dout[d]}), 64'(0));
    end
    repeat (3) step();
    rst_n = 1'b1;

    n = 0;
    repeat (1000) begin
      step();
      if (ts[0] || ts[1] || bsy[0] || bsy[1]) n++;
    end
    chk("idle after release", n, 0);

    rmode[0] = 1;
    rd[0][23:16] = 8'hA5;
    rv[0] = 4'b0100;
    step();
    chk("single tx_start", ts[0], 1);
    chk("single din", dout[0], 8'hA5);
    chk("single req_ready", rdy[0], 4'b0100);
    chk("single grant_id", gid[0], 2);
    n = 0;
    k = 0;
    while (bsy[0] && k < 3000) begin
      step();
      k++;
      if (ts[0]) n++;
    end
    chk("single no restart", n, 0);
    chk("single back idle", bsy[0], 0);

    for (int t = 0; t < 5; t++) begin
      do_reset();
      rv[tv[t].d] = tv[t].pat;
      wait_grants(tv[t].d, NG, 5000);
      for (int j = 0; j < NG; j++) begin
        chk($sformatf("table%0d grant%0d", t, j),
            glog[tv[t].d][j], tv[t].exp_g[j]);
      end
      rv[tv[t].d] = '0;
    end

    do_reset();
    rv[0] = 4'b1111;
    wait_grants(0, 3, 3000);
    repeat (20) step();
    #1 rst_n = 1'b0;
    #1;
    chk("mid reset outputs",
        64'({ts[0], bsy[0], rdy[0], gid[0], dout[0]}), 64'(0));
    chk("mid reset busy", bsy[0], 0);
    step();
    step();
    rst_n = 1'b1;
    wait_grants(0, 1, 100);
    chk("post reset grant", glog[0][0], 0);

    do_reset();
    rmode[0] = 2;
    rmode[1] = 2;
    repeat (12000) step();
    for (int d = 0; d < ND; d++) begin
      rmode[d] = 0;
      rv[d]    = '0;
    end
    k = 0;
    while ((bsy[0] || bsy[1]) && k < 3000) begin
      step();
      k++;
    end
    chk("drain idle", 64'({bsy[0], bsy[1]}), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
